// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BIN_W_DEF  = 14;
    localparam int DIGITS_DEF = 4;

    localparam int          BCD_MAX = 9999;
    localparam logic [15:0] BCD_SAT = 16'h9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit cell: a BCD digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // 4-bit wrap-around add; a legal digit never carries out.
    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter, one input bit per clock, saturating at 9999.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_q;
    logic [BIN_W-1:0]   shift_q;
    logic [BCD_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_pend_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;

    logic [BCD_W-1:0]       acc_adj;
    logic [BCD_W+BIN_W-1:0] cat_adj;
    logic [BCD_W-1:0]       acc_d;
    logic [BIN_W-1:0]       shift_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    // Adjusted accumulator and shift register move left together as one word.
    assign cat_adj = {acc_adj, shift_q};
    assign acc_d   = cat_adj[BCD_W+BIN_W-2 -: BCD_W];
    assign shift_d = {shift_q[BIN_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too so an aborted conversion leaves no residue.
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        shift_q    <= bin_in;
                        acc_q      <= '0;
                        cnt_q      <= CNT_W'(BIN_W);
                        ovf_pend_q <= (bin_in > BIN_W'(BCD_MAX));
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_q   <= acc_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q - 1'b1;
                    // Last shift: publish the result in the same edge that enters DONE.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= ovf_pend_q ? BCD_W'(BCD_SAT) : acc_d;
                        ovf_q   <= ovf_pend_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: decimal reference model feeding a result scoreboard.
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_cyc    = 0;
    exp_t sb[$];
    logic [15:0] exp_bcd_held = 16'h0000;
    logic        exp_ovf_held = 1'b0;

    bin_to_bcd_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int v);
        exp_t e;
        if (v > 9999) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_conv(input int v);
        bin_in = 14'(v);
        start  = 1'b1;
        sb.push_back(model(v));
        n_cyc  = cyc;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit   hold_bad = 1'b0;
        bit   busy_bad = 1'b0;
        exp_t e;
        while (done !== 1'b1 && (cyc - n_cyc) < 25) begin
            if (bcd_out !== exp_bcd_held || ovf !== exp_ovf_held) hold_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
            step();
        end
        check({tag, "_latency"}, 32'(cyc - n_cyc), 32'd15);
        check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
        check({tag, "_hold_during"}, 32'(hold_bad), 32'd0);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_bcd"}, 32'(bcd_out), 32'(e.bcd));
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            exp_bcd_held = e.bcd;
            exp_ovf_held = e.ovf;
        end
    endtask

    task automatic check_single_pulse(input string tag);
        step();
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_bcd_hold_after"}, 32'(bcd_out), 32'(exp_bcd_held));
    endtask

    initial begin
        bit stray_done;

        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        step();

        start_conv(0);     wait_done("zero");   check_single_pulse("zero");
        start_conv(1234);  wait_done("v1234");  check_single_pulse("v1234");
        start_conv(9999);  wait_done("v9999");  check_single_pulse("v9999");
        start_conv(10000); wait_done("v10000"); check_single_pulse("v10000");
        start_conv(16383); wait_done("v16383"); check_single_pulse("v16383");

        // Second start and input churn while busy must not disturb the result.
        start_conv(1234);
        repeat (4) step();
        bin_in = 14'd5678;
        start  = 1'b1;
        step();
        start  = 1'b0;
        bin_in = 14'd3333;
        wait_done("ignore");
        check_single_pulse("ignore");

        // Reset at N+7 aborts the conversion.
        start_conv(4321);
        repeat (6) step();
        rst = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        void'(sb.pop_back());
        exp_bcd_held = 16'h0000;
        exp_ovf_held = 1'b0;
        stray_done = 1'b0;
        repeat (20) begin
            step();
            if (done !== 1'b0) stray_done = 1'b1;
        end
        check("abort_no_done", 32'(stray_done), 32'd0);
        start_conv(4321);  wait_done("after_abort"); check_single_pulse("after_abort");

        // Back-to-back: second start issued in the DONE cycle.
        start_conv(42);
        wait_done("b2b_first");
        start_conv(807);
        wait_done("b2b_second");
        check_single_pulse("b2b_second");

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
